// File: rtl/uart_rx_oversample.sv
// ============================================================================
// uart_rx_oversample
//
// Oversampling UART receive framer that sits directly upstream of the Rx FIFO.
// It recovers 8N1 frames from the asynchronous serial pin. The front end is a
// two-flop synchroniser followed by an edge-detect register. Bit timing runs
// from a programmable 16x tick. Each bit is decided by a mid-bit majority vote
// of the samples taken at ticks 7, 8 and 9. A start bit that does not hold low
// at mid-bit is rejected as a glitch.
//
// Optional feature: define UART_RX_PARITY_EN to add a parity bit between the
// data and stop bits (8E1 / 8O1, sense selected by PARITY_ODD). Without the
// macro the frame is 8N1 and perr_o is tied low.
//
// Parameters:
//   OVERSAMPLE  ticks per bit; fixed at 16
//   PARITY_ODD  parity sense with UART_RX_PARITY_EN (0 = even, 1 = odd)
//
// Ports:
//   clk_i        system clock
//   syncReset_i  synchronous reset, active-high
//   rate_i       clk cycles per oversample tick, minus 1 (0 = tick every cycle)
//   in_i         asynchronous serial line, idles high
//   data_o       last received byte (LSB first on the wire)
//   done_o       one-cycle strobe: byte complete
//   err_o        framing error qualifier, valid with done_o
//   perr_o       parity error qualifier, valid with done_o
//   busy_o       high whenever the receiver is not idle
// ============================================================================
module uart_rx_oversample #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic        clk_i,
    input  logic        syncReset_i,
    input  logic [15:0] rate_i,
    input  logic        in_i,
    output logic [7:0]  data_o,
    output logic        done_o,
    output logic        err_o,
    output logic        perr_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_e;

    localparam logic [3:0] LastTick = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] Vote0Tick = 4'd7;
    localparam logic [3:0] Vote1Tick = 4'd8;
    localparam logic [3:0] MidTick = 4'd9;

    // Synchroniser and edge-detect registers
    logic        sync1_q, sync2_q, prev_q;

    // Frame state and bit timing
    state_e      state_q, state_d;
    logic [15:0] tickCnt_q, tickCnt_d;
    logic [3:0]  sampleCnt_q, sampleCnt_d;
    logic [2:0]  bitIdx_q, bitIdx_d;
    logic [1:0]  votes_q, votes_d;
    logic [7:0]  shift_q, shift_d;

    // Registered outputs
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        perr_q, perr_d;
    logic        busy_q, busy_d;

`ifdef UART_RX_PARITY_EN
    logic        parBit_q, parBit_d;
`else
    // Parity sense only matters when the parity stage is built.
    logic        unusedParity;
    assign unusedParity = ^PARITY_ODD;
`endif

    logic fallEdge;
    logic tick;
    logic bitMid;
    logic bitEnd;
    logic majority;

    assign fallEdge = prev_q & ~sync2_q;

    // Using >= rather than == means a rate decrease below the running count
    // takes effect at once instead of waiting for a 16-bit wrap.
    assign tick = (tickCnt_q >= rate_i);
    assign bitMid = tick && (sampleCnt_q == MidTick);
    assign bitEnd = tick && (sampleCnt_q == LastTick);

    // Two stored samples (ticks 7, 8) vote with the live tick-9 sample.
    assign majority = (votes_q[0] & votes_q[1]) |
                      (votes_q[0] & sync2_q) |
                      (votes_q[1] & sync2_q);

    // Next-state logic. The tick counter and sample count are held at zero
    // while idle, so bit timing starts fresh from the detected falling edge.
    always_comb begin
        state_d = state_q;
        tickCnt_d = tickCnt_q;
        sampleCnt_d = sampleCnt_q;
        bitIdx_d = bitIdx_q;
        votes_d = votes_q;
        shift_d = shift_q;
        data_d = data_q;
        done_d = 1'b0;
        err_d = 1'b0;
        perr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parBit_d = parBit_q;
`endif

        if (state_q == IDLE || state_q == WAIT_IDLE) begin
            tickCnt_d = 16'd0;
            sampleCnt_d = 4'd0;
        end else if (tick) begin
            tickCnt_d = 16'd0;
            sampleCnt_d = sampleCnt_q + 4'd1;
        end else begin
            tickCnt_d = tickCnt_q + 16'd1;
        end

        if (tick && sampleCnt_q == Vote0Tick) begin
            votes_d[0] = sync2_q;
        end
        if (tick && sampleCnt_q == Vote1Tick) begin
            votes_d[1] = sync2_q;
        end

        case (state_q)
            IDLE: begin
                if (fallEdge) begin
                    state_d = START;
                end
            end

            START: begin
                if (bitMid && majority) begin
                    state_d = IDLE;
                end else if (bitEnd) begin
                    state_d = DATA;
                    bitIdx_d = 3'd0;
                end
            end

            DATA: begin
                if (bitMid) begin
                    shift_d[bitIdx_q] = majority;
                end
                if (bitEnd) begin
                    if (bitIdx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bitMid) begin
                    parBit_d = majority;
                end
                if (bitEnd) begin
                    state_d = STOP;
                end
            end
`endif

            // The byte is presented at mid stop bit and the receiver returns
            // to IDLE early, so a start bit immediately following the stop
            // bit is still seen as a falling edge.
            STOP: begin
                if (bitMid) begin
                    data_d = shift_q;
                    done_d = 1'b1;
                    err_d = ~majority;
`ifdef UART_RX_PARITY_EN
                    perr_d = (((^shift_q) ^ parBit_q) != PARITY_ODD[0]);
`endif
                    state_d = majority ? IDLE : WAIT_IDLE;
                end
            end

            // A held-low line (break) reports one framing error, then waits
            // here so it cannot be mistaken for a stream of start bits.
            WAIT_IDLE: begin
                if (sync2_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // All state, including the synchroniser, updates in one clocked block.
    // Synchroniser flops reset high so the idle line never looks like an edge.
    always_ff @(posedge clk_i) begin
        if (syncReset_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q <= 1'b1;
            state_q <= IDLE;
            tickCnt_q <= 16'd0;
            sampleCnt_q <= 4'd0;
            bitIdx_q <= 3'd0;
            votes_q <= 2'b00;
            shift_q <= 8'd0;
            data_q <= 8'd0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            perr_q <= 1'b0;
            busy_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parBit_q <= 1'b0;
`endif
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
            prev_q <= sync2_q;
            state_q <= state_d;
            tickCnt_q <= tickCnt_d;
            sampleCnt_q <= sampleCnt_d;
            bitIdx_q <= bitIdx_d;
            votes_q <= votes_d;
            shift_q <= shift_d;
            data_q <= data_d;
            done_q <= done_d;
            err_q <= err_d;
            perr_q <= perr_d;
            busy_q <= busy_d;
`ifdef UART_RX_PARITY_EN
            parBit_q <= parBit_d;
`endif
        end
    end

    assign data_o = data_q;
    assign done_o = done_q;
    assign err_o = err_q;
    assign perr_o = perr_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// ============================================================================
// tb_uart_rx_oversample
//
// Directed-vector bench for uart_rx_oversample. Stimulus tasks drive serial
// frames onto the line and push the hand-computed expected byte and flags
// into a queue. A separate monitor pops that queue whenever the receiver
// strobes done and compares data, err and perr.
// ============================================================================
module tb_uart_rx_oversample;

    typedef struct {
        logic [7:0] data;
        logic       err;
        logic       perr;
    } expect_t;

`ifdef UART_RX_PARITY_EN
    localparam int LatNom = 172;
`else
    localparam int LatNom = 156;
`endif

    logic        clk = 1'b0;
    logic        syncReset;
    logic [15:0] rate;
    logic        rxIn;
    logic [7:0]  data;
    logic        done;
    logic        err;
    logic        perr;
    logic        busy;

    expect_t     expQ[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          doneCount = 0;
    int          lastDoneCyc = 0;
    bit          monitorOn = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic        parFlip = 1'b0;
`endif

    uart_rx_oversample dut (
        .clk_i      (clk),
        .syncReset_i(syncReset),
        .rate_i     (rate),
        .in_i       (rxIn),
        .data_o     (data),
        .done_o     (done),
        .err_o      (err),
        .perr_o     (perr),
        .busy_o     (busy)
    );

    // Free-running clock and cycle counter for latency measurement
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Single comparison with its own FAIL line
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushExpect(input logic [7:0] d, input logic e, input logic p);
        expect_t x;
        x.data = d;
        x.err = e;
        x.perr = p;
        expQ.push_back(x);
    endtask

    // Hold the line for a number of clock edges; returns 1ns after an edge
    task automatic holdLine(input logic v, input int cycles);
        rxIn = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Send one frame. glitchBit >= 0 flips the single sample the receiver
    // takes at tick 8 of that data bit (rate 0 only: the 2-cycle synchroniser
    // delay puts tick 8 on the 10th edge of the bit).
    task automatic applyStimulus(input logic [7:0] d, input logic stopBit,
                                 input int glitchBit, input int r);
        int bpc;
        bpc = 16 * (r + 1);
        holdLine(1'b0, bpc);
        for (int i = 0; i < 8; i++) begin
            if (i == glitchBit) begin
                holdLine(d[i], 9);
                holdLine(~d[i], 1);
                holdLine(d[i], bpc - 10);
            end else begin
                holdLine(d[i], bpc);
            end
        end
`ifdef UART_RX_PARITY_EN
        holdLine((^d) ^ parFlip, bpc);
`endif
        holdLine(stopBit, bpc);
    endtask

    // Scoreboard monitor: compares every done strobe against the queue, and
    // checks the qualifiers stay low while done is low.
    always @(negedge clk) begin : monitor
        expect_t e;
        if (monitorOn) begin
            if (done === 1'b1) begin
                doneCount++;
                lastDoneCyc = cyc;
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpectedDone: got strobe with data 0x%0h, expected none", data);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("doneData", {24'd0, data}, {24'd0, e.data});
                    checkOutput("doneErr", {31'd0, err}, {31'd0, e.err});
                    checkOutput("donePerr", {31'd0, perr}, {31'd0, e.perr});
                end
            end else begin
                checkOutput("qualifiersIdle", {30'd0, err, perr}, 32'd0);
            end
        end
    end

    initial begin
        int fallCyc;
        int lat;
        int prevCount;

        rxIn = 1'b1;
        syncReset = 1'b1;
        rate = 16'd0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        checkOutput("rstData", {24'd0, data}, 32'd0);
        checkOutput("rstDone", {31'd0, done}, 32'd0);
        checkOutput("rstErr", {31'd0, err}, 32'd0);
        checkOutput("rstPerr", {31'd0, perr}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        syncReset = 1'b0;
        monitorOn = 1'b1;
        holdLine(1'b1, 20);

        // 0xA5 at rate 0: one strobe, latency 156 +-1 from the falling edge
        $display("[TB] frame 0xA5 at rate 0");
        prevCount = doneCount;
        fallCyc = cyc;
        pushExpect(8'hA5, 1'b0, 1'b0);
        applyStimulus(8'hA5, 1'b1, -1, 0);
        holdLine(1'b1, 16);
        checkOutput("a5Strobes", doneCount - prevCount, 1);
        lat = lastDoneCyc - fallCyc;
        checks++;
        if (lat < LatNom - 1 || lat > LatNom + 1) begin
            failures++;
            $display("[TB] FAIL a5Latency: got %0d cycles, expected %0d +-1", lat, LatNom);
        end
        checkOutput("a5BusyIdle", {31'd0, busy}, 32'd0);

        // Short low glitch: no strobe, receiver returns to idle
        $display("[TB] 4-cycle glitch at rate 0");
        prevCount = doneCount;
        holdLine(1'b0, 4);
        checkOutput("glitchBusy", {31'd0, busy}, 32'd1);
        holdLine(1'b1, 16);
        checkOutput("glitchBusyIdle", {31'd0, busy}, 32'd0);
        checkOutput("glitchStrobes", doneCount - prevCount, 0);

        // Framing error followed by a 40-bit break, then a clean byte
        $display("[TB] 0x3C with bad stop and break at rate 3");
        rate = 16'd3;
        holdLine(1'b1, 64);
        prevCount = doneCount;
        pushExpect(8'h3C, 1'b1, 1'b0);
        applyStimulus(8'h3C, 1'b0, -1, 3);
        holdLine(1'b0, 40 * 64);
        checkOutput("breakBusy", {31'd0, busy}, 32'd1);
        checkOutput("breakStrobes", doneCount - prevCount, 1);
        holdLine(1'b1, 128);
        checkOutput("breakBusyIdle", {31'd0, busy}, 32'd0);
        pushExpect(8'h81, 1'b0, 1'b0);
        applyStimulus(8'h81, 1'b1, -1, 3);
        holdLine(1'b1, 128);

        // Back-to-back frames with no idle gap
        $display("[TB] back-to-back 0x00, 0xFF at rate 0");
        rate = 16'd0;
        holdLine(1'b1, 32);
        prevCount = doneCount;
        pushExpect(8'h00, 1'b0, 1'b0);
        pushExpect(8'hFF, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b1, -1, 0);
        applyStimulus(8'hFF, 1'b1, -1, 0);
        holdLine(1'b1, 32);
        checkOutput("b2bStrobes", doneCount - prevCount, 2);

        // One corrupted mid-bit sample is outvoted
        $display("[TB] 0x55 with tick-8 sample of bit 3 flipped");
        pushExpect(8'h55, 1'b0, 1'b0);
        applyStimulus(8'h55, 1'b1, 3, 0);
        holdLine(1'b1, 32);

`ifdef UART_RX_PARITY_EN
        // Wrong even parity on 0x07 flags perr but not err
        $display("[TB] 0x07 with parity bit 0");
        parFlip = 1'b1;
        pushExpect(8'h07, 1'b0, 1'b1);
        applyStimulus(8'h07, 1'b1, -1, 0);
        parFlip = 1'b0;
        holdLine(1'b1, 32);
`endif

        // Reset in the middle of a frame aborts it without a strobe
        $display("[TB] reset mid-frame");
        holdLine(1'b0, 16);
        holdLine(1'b1, 16);
        holdLine(1'b1, 16);
        holdLine(1'b1, 8);
        checkOutput("midFrameBusy", {31'd0, busy}, 32'd1);
        prevCount = doneCount;
        syncReset = 1'b1;
        rxIn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abortData", {24'd0, data}, 32'd0);
        checkOutput("abortDone", {31'd0, done}, 32'd0);
        checkOutput("abortErr", {31'd0, err}, 32'd0);
        checkOutput("abortPerr", {31'd0, perr}, 32'd0);
        checkOutput("abortBusy", {31'd0, busy}, 32'd0);
        syncReset = 1'b0;
        holdLine(1'b1, 200);
        checkOutput("abortStrobes", doneCount - prevCount, 0);

        checkOutput("queueEmpty", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
